riscv_operand_stage: RTL and testbench

Issue/operand stage directly upstream of the core ALU. It accepts decoded instructions and reads source operands from an internal 32×32 register file. It detects RAW/WAW hazards with a pending-write scoreboard and registers the selected A/B operands plus ALUOp into a one-entry output buffer. That buffer feeds the ALU/execute stage over a valid/ready handshake. The writeback port updates the register file and retires scoreboard entries.

---
 rtl/riscv_operand_stage_pkg.sv | 34 +++
 rtl/riscv_regfile.sv | 43 ++++
 rtl/riscv_operand_stage.sv | 124 ++++++++++++
 tb/tb_riscv_operand_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_operand_stage_pkg.sv
// Shared encodings for the operand stage: ALU opcodes and A/B operand selects.
`default_nettype none

package ALUOps;
  localparam int ALUOP_W = 5;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 5'b00000,
    ALU_SUB  = 5'b00001,
    ALU_AND  = 5'b00010,
    ALU_OR   = 5'b00011,
    ALU_XOR  = 5'b00100,
    ALU_SLL  = 5'b00101,
    ALU_SRL  = 5'b00110,
    ALU_SRA  = 5'b00111,
    ALU_SLT  = 5'b01000,
    ALU_SLTU = 5'b01001
  } alu_op_e;
endpackage

package RegSelOps;
  typedef enum logic [1:0] {
    ASEL_RS1  = 2'd0,
    ASEL_PC   = 2'd1,
    ASEL_ZERO = 2'd2
  } a_sel_e;

  typedef enum logic {
    BSEL_RS2 = 1'b0,
    BSEL_IMM = 1'b1
  } b_sel_e;
endpackage

`default_nettype wire

// File: rtl/riscv_regfile.sv
// riscv_regfile: 32 x XLEN register file, two write-through read ports, one write port.
`default_nettype none

module riscv_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs [32];

  // x0 is reset to zero and never written, so it stays hardwired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en && wr_addr != 5'd0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    if (rs1_addr == 5'd0)                     rs1_data = '0;
    else if (wr_en && wr_addr == rs1_addr)    rs1_data = wr_data;
    else                                      rs1_data = regs[rs1_addr];
  end

  always_comb begin
    if (rs2_addr == 5'd0)                     rs2_data = '0;
    else if (wr_en && wr_addr == rs2_addr)    rs2_data = wr_data;
    else                                      rs2_data = regs[rs2_addr];
  end

endmodule

`default_nettype wire

// File: rtl/riscv_operand_stage.sv
// riscv_operand_stage: operand read, RAW/WAW scoreboard and one-entry output buffer
// feeding the ALU over valid/ready.
`default_nettype none

module riscv_operand_stage
  import ALUOps::*;
  import RegSelOps::*;
#(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               InValid,
  output logic               InReady,
  input  logic [4:0]         InRs1,
  input  logic [4:0]         InRs2,
  input  logic [4:0]         InRd,
  input  logic               InRdWe,
  input  logic [1:0]         InASel,
  input  logic               InBSel,
  input  logic [XLEN-1:0]    InImm,
  input  logic [XLEN-1:0]    InPC,
  input  logic [ALUOP_W-1:0] InALUOp,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [XLEN-1:0]    OutA,
  output logic [XLEN-1:0]    OutB,
  output logic [ALUOP_W-1:0] OutALUOp,
  output logic [XLEN-1:0]    OutRs2Data,
  output logic [XLEN-1:0]    OutPC,
  output logic [4:0]         OutRd,
  output logic               OutRdWe,
  input  logic               WbValid,
  input  logic [4:0]         WbRd,
  input  logic [XLEN-1:0]    WbData,
  input  logic               Flush
);

  logic [31:0]     pending;
  logic [31:0]     pending_nxt;
  logic [31:0]     wb_mask;
  logic [31:0]     pend_eff;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] a_val;
  logic [XLEN-1:0] b_val;
  logic            hazard;
  logic            accept;
  logic            kill_writer;

  riscv_regfile #(.XLEN(XLEN)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (InRs1),
    .rs2_addr (InRs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wr_en    (WbValid),
    .wr_addr  (WbRd),
    .wr_data  (WbData)
  );

  // A writeback landing this cycle retires its register early so the reader can bypass.
  assign wb_mask  = WbValid ? (32'd1 << WbRd) : 32'd0;
  assign pend_eff = pending & ~wb_mask;

  assign hazard = ((InRs1 != 5'd0) && pend_eff[InRs1])
               || ((InRs2 != 5'd0) && pend_eff[InRs2])
               || (InRdWe && (InRd != 5'd0) && pend_eff[InRd]);

  assign InReady     = rst_n && (!OutValid || OutReady) && !hazard && !Flush;
  assign accept      = InValid && InReady;
  assign kill_writer = Flush && OutValid && OutRdWe && (OutRd != 5'd0);

  always_comb begin
    pending_nxt = pending;
    if (WbValid)     pending_nxt[WbRd]  = 1'b0;
    if (kill_writer) pending_nxt[OutRd] = 1'b0;
    if (accept && InRdWe && InRd != 5'd0) pending_nxt[InRd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_comb begin
    case (InASel)
      ASEL_RS1: a_val = rs1_data;
      ASEL_PC:  a_val = InPC;
      default:  a_val = '0;
    endcase
    b_val = (InBSel == BSEL_IMM) ? InImm : rs2_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      OutValid   <= 1'b0;
      OutA       <= '0;
      OutB       <= '0;
      OutALUOp   <= '0;
      OutRs2Data <= '0;
      OutPC      <= '0;
      OutRd      <= '0;
      OutRdWe    <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (Flush) begin
        OutValid <= 1'b0;
      end else if (accept) begin
        OutValid   <= 1'b1;
        OutA       <= a_val;
        OutB       <= b_val;
        OutALUOp   <= InALUOp;
        OutRs2Data <= rs2_data;
        OutPC      <= InPC;
        OutRd      <= InRd;
        OutRdWe    <= InRdWe;
      end else if (OutReady) begin
        OutValid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_operand_stage.sv
// tb_riscv_operand_stage: vector table, directed corner sequences and random traffic
// checked against a behavioural model of the operand stage.
`default_nettype none

module tb_riscv_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        InValid, InReady, InRdWe, InBSel;
  logic [4:0]  InRs1, InRs2, InRd, InALUOp;
  logic [1:0]  InASel;
  logic [31:0] InImm, InPC;
  logic        OutValid, OutReady, OutRdWe;
  logic [31:0] OutA, OutB, OutRs2Data, OutPC;
  logic [4:0]  OutALUOp, OutRd;
  logic        WbValid, Flush;
  logic [4:0]  WbRd;
  logic [31:0] WbData;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_operand_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .InValid(InValid), .InReady(InReady), .InRs1(InRs1), .InRs2(InRs2),
    .InRd(InRd), .InRdWe(InRdWe), .InASel(InASel), .InBSel(InBSel),
    .InImm(InImm), .InPC(InPC), .InALUOp(InALUOp),
    .OutValid(OutValid), .OutReady(OutReady), .OutA(OutA), .OutB(OutB),
    .OutALUOp(OutALUOp), .OutRs2Data(OutRs2Data), .OutPC(OutPC),
    .OutRd(OutRd), .OutRdWe(OutRdWe),
    .WbValid(WbValid), .WbRd(WbRd), .WbData(WbData), .Flush(Flush)
  );

  // Behavioural model state: architectural registers, in-flight writers, buffer contents.
  logic [31:0] mregs [32];
  bit          mpend [32];
  bit          mv, mrdwe;
  logic [31:0] ma, mb, mrs2, mpc;
  logic [4:0]  mop, mrd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = 32'd0;
      mpend[i] = 1'b0;
    end
    mv = 0; mrdwe = 0; ma = 0; mb = 0; mrs2 = 0; mpc = 0; mop = 0; mrd = 0;
  endtask

  function automatic logic [31:0] mread(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (WbValid && WbRd == r) return WbData;
    return mregs[r];
  endfunction

  function automatic bit mbusy(input logic [4:0] r);
    return (r != 5'd0) && mpend[r] && !(WbValid && WbRd == r);
  endfunction

  function automatic bit m_ready();
    bit hz;
    hz = mbusy(InRs1) || mbusy(InRs2) || (InRdWe && mbusy(InRd));
    return (!mv || OutReady) && !hz && !Flush;
  endfunction

  task automatic check_outs();
    chk("out_valid", 32'(OutValid), 32'(mv));
    chk("out_a",     OutA,        ma);
    chk("out_b",     OutB,        mb);
    chk("out_rs2",   OutRs2Data,  mrs2);
    chk("out_pc",    OutPC,       mpc);
    chk("out_op",    32'(OutALUOp), 32'(mop));
    chk("out_rd",    32'(OutRd),  32'(mrd));
    chk("out_rdwe",  32'(OutRdWe), 32'(mrdwe));
  endtask

  // One clock: check InReady, advance the model, clock, check the buffer.
  task automatic step();
    bit rdy, acc;
    logic [31:0] ra, rb, a, b;
    #1;
    rdy = m_ready();
    chk("in_ready", 32'(InReady), 32'(rdy));
    acc = InValid && rdy;
    ra = mread(InRs1);
    rb = mread(InRs2);
    a  = (InASel == 2'd0) ? ra : (InASel == 2'd1) ? InPC : 32'd0;
    b  = InBSel ? InImm : rb;
    if (WbValid) mpend[WbRd] = 1'b0;
    if (Flush && mv && mrdwe && mrd != 5'd0) mpend[mrd] = 1'b0;
    if (acc && InRdWe && InRd != 5'd0) mpend[InRd] = 1'b1;
    if (WbValid && WbRd != 5'd0) mregs[WbRd] = WbData;
    if (Flush) mv = 0;
    else if (acc) begin
      mv = 1; ma = a; mb = b; mrs2 = rb; mpc = InPC; mop = InALUOp;
      mrd = InRd; mrdwe = InRdWe;
    end else if (OutReady) mv = 0;
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rdwe, input logic [1:0] asel, input logic bsel,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] op);
    InValid = 1; InRs1 = rs1; InRs2 = rs2; InRd = rd; InRdWe = rdwe;
    InASel = asel; InBSel = bsel; InImm = imm; InPC = pc; InALUOp = op;
  endtask

  typedef struct {
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic [4:0]  rs1, rs2;
    logic [1:0]  asel;
    logic        bsel;
    logic [31:0] imm, pc;
    logic [4:0]  op;
    logic [31:0] ea, eb, ers2;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_a;
    int pick;
    tbl[0] = '{1'b1, 5'd4, 32'hA5A50001, 5'd4, 5'd0, 2'd0, 1'b1, 32'hFFFFFFF0, 32'h100, 5'd1,
               32'hA5A50001, 32'hFFFFFFF0, 32'h0};
    tbl[1] = '{1'b1, 5'd6, 32'h00001234, 5'd4, 5'd6, 2'd1, 1'b0, 32'h7, 32'h200, 5'd2,
               32'h200, 32'h1234, 32'h1234};
    tbl[2] = '{1'b0, 5'd0, 32'h0, 5'd4, 5'd6, 2'd2, 1'b1, 32'h8, 32'h204, 5'd3,
               32'h0, 32'h8, 32'h1234};
    tbl[3] = '{1'b0, 5'd0, 32'h0, 5'd6, 5'd4, 2'd3, 1'b0, 32'h9, 32'h208, 5'd4,
               32'h0, 32'hA5A50001, 32'hA5A50001};
    tbl[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 2'd0, 1'b0, 32'h0, 32'h20C, 5'd5,
               32'h0, 32'h0, 32'h0};
    tbl[5] = '{1'b1, 5'd4, 32'h00000001, 5'd4, 5'd4, 2'd0, 1'b0, 32'h0, 32'h210, 5'd6,
               32'h1, 32'h1, 32'h1};

    rst_n = 0; OutReady = 1; Flush = 0; WbValid = 0; WbRd = 0; WbData = 0;
    InValid = 0; InRs1 = 0; InRs2 = 0; InRd = 0; InRdWe = 0; InASel = 0; InBSel = 0;
    InImm = 0; InPC = 0; InALUOp = 0;
    model_reset();
    #2;
    chk("rst_in_ready", 32'(InReady), 32'd0);
    check_outs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // Operand-select vector table.
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].rs1, tbl[i].rs2, 5'd0, 1'b0, tbl[i].asel, tbl[i].bsel,
            tbl[i].imm, tbl[i].pc, tbl[i].op);
      WbValid = tbl[i].wbv; WbRd = tbl[i].wbrd; WbData = tbl[i].wbd;
      step();
      chk("vec_a",   OutA,       tbl[i].ea);
      chk("vec_b",   OutB,       tbl[i].eb);
      chk("vec_rs2", OutRs2Data, tbl[i].ers2);
    end
    InValid = 0; WbValid = 0; step();

    // Writeback then read with immediate B operand.
    WbValid = 1; WbRd = 5'd3; WbData = 32'h11; step();
    WbValid = 0;
    issue(5'd3, 5'd0, 5'd0, 1'b0, 2'd0, 1'b1, 32'd5, 32'h400, 5'b00000); step();
    chk("t1_a", OutA, 32'h11);
    chk("t1_b", OutB, 32'h5);
    chk("t1_op", 32'(OutALUOp), 32'd0);
    InValid = 0; step();

    // RAW stall until writeback, then bypass in the same cycle.
    issue(5'd0, 5'd0, 5'd5, 1'b1, 2'd0, 1'b1, 32'd1, 32'h500, 5'd0); step();
    issue(5'd5, 5'd0, 5'd0, 1'b0, 2'd0, 1'b1, 32'd2, 32'h504, 5'd1);
    #1 chk("t2_stall", 32'(InReady), 32'd0);
    step(); step();
    WbValid = 1; WbRd = 5'd5; WbData = 32'hDEADBEEF; step();
    chk("t2_bypass", OutA, 32'hDEADBEEF);
    chk("t2_valid", 32'(OutValid), 32'd1);
    WbValid = 0; InValid = 0; step();

    // Backpressure: buffer holds for three cycles, then drains and refills together.
    OutReady = 0;
    issue(5'd0, 5'd0, 5'd0, 1'b0, 2'd1, 1'b1, 32'd1, 32'h300, 5'd2); step();
    held_a = OutA;
    issue(5'd0, 5'd0, 5'd0, 1'b0, 2'd1, 1'b1, 32'd2, 32'h304, 5'd3);
    repeat (3) begin
      step();
      chk("t3_hold_pc", OutPC, 32'h300);
      chk("t3_hold_a", OutA, held_a);
    end
    OutReady = 1; step();
    chk("t3_next_pc", OutPC, 32'h304);
    InValid = 0; step();

    // x0: writes ignored, writers of x0 never stall.
    WbValid = 1; WbRd = 5'd0; WbData = 32'hFFFFFFFF;
    issue(5'd0, 5'd0, 5'd0, 1'b1, 2'd0, 1'b0, 32'd0, 32'h600, 5'd0); step();
    WbValid = 0;
    issue(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 32'd0, 32'h604, 5'd0);
    #1 chk("t4_x0_ready", 32'(InReady), 32'd1);
    step();
    chk("t4_x0_a", OutA, 32'd0);
    InValid = 0; step();

    // Flush kills a buffered writer of x7 and releases its scoreboard entry.
    OutReady = 0;
    issue(5'd0, 5'd0, 5'd7, 1'b1, 2'd0, 1'b1, 32'd7, 32'h700, 5'd0); step();
    InValid = 1; Flush = 1; InRs1 = 5'd1; InRdWe = 0; step();
    chk("t5_flush_valid", 32'(OutValid), 32'd0);
    Flush = 0; OutReady = 1;
    issue(5'd7, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 32'd0, 32'h704, 5'd1);
    #1 chk("t5_x7_ready", 32'(InReady), 32'd1);
    step();
    InValid = 0; step();

    // Asynchronous reset with a writer of x9 in flight.
    OutReady = 0;
    issue(5'd0, 5'd0, 5'd9, 1'b1, 2'd1, 1'b1, 32'd9, 32'h900, 5'd4); step();
    InValid = 0;
    #3 rst_n = 0;
    #1;
    model_reset();
    chk("t6_rst_valid", 32'(OutValid), 32'd0);
    chk("t6_rst_ready", 32'(InReady), 32'd0);
    chk("t6_rst_pc", OutPC, 32'd0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    OutReady = 1;
    issue(5'd9, 5'd9, 5'd0, 1'b0, 2'd0, 1'b0, 32'd0, 32'h904, 5'd0);
    #1 chk("t6_x9_ready", 32'(InReady), 32'd1);
    step();
    chk("t6_x9_a", OutA, 32'd0);

    // Random traffic on a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      InValid  = ($urandom_range(0, 3) != 0);
      InRs1    = 5'($urandom_range(0, 7));
      InRs2    = 5'($urandom_range(0, 7));
      InRd     = 5'($urandom_range(0, 7));
      InRdWe   = 1'($urandom_range(0, 1));
      InASel   = 2'($urandom_range(0, 3));
      InBSel   = 1'($urandom_range(0, 1));
      InImm    = $urandom;
      InPC     = $urandom;
      InALUOp  = 5'($urandom_range(0, 31));
      OutReady = ($urandom_range(0, 3) != 0);
      Flush    = ($urandom_range(0, 19) == 0);
      WbValid  = ($urandom_range(0, 9) < 4);
      WbData   = $urandom;
      WbRd     = 5'($urandom_range(0, 7));
      pick     = int'($urandom_range(0, 7));
      for (int k = 0; k < 8; k++) begin
        if (mpend[(pick + k) % 8]) begin
          WbRd = 5'((pick + k) % 8);
          break;
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
